// File: rtl/simd_fetch_pkg.sv
// Shared types for the warp fetch stage: per-warp run state, default widths, fetch packet layout.
package simd_fetch_pkg;
  localparam int NUM_WARP_DEF = 8;
  localparam int FETCH_W_DEF  = 2;
  localparam int PC_W_DEF     = 32;
  localparam int INST_W_DEF   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } warp_state_e;

  // One slot of pkt_o at default widths: {inst, pc}
  typedef struct packed {
    logic [INST_W_DEF-1:0] inst;
    logic [PC_W_DEF-1:0]   pc;
  } fetch_pkt_t;
endpackage

// File: rtl/warp_fetch_unit_if.sv
// Fetch-stage bus: decode/issue control in, I-cache read and instruction packets out.
interface warp_fetch_unit_if #(
  parameter int NUM_WARP = 8,
  parameter int FETCH_W  = 2,
  parameter int PC_W     = 32,
  parameter int INST_W   = 64
);
  localparam int WARP_LOG = $clog2(NUM_WARP);
  localparam int SLOT_LOG = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  logic                              stall_i;
  logic                              launch_valid_i;
  logic [WARP_LOG-1:0]               launch_warp_i;
  logic [PC_W-1:0]                   launch_pc_i;
  logic                              redir_valid_i;
  logic [WARP_LOG-1:0]               redir_warp_i;
  logic [PC_W-1:0]                   redir_pc_i;
  logic                              exit_valid_i;
  logic [WARP_LOG-1:0]               exit_warp_i;
  logic                              issue_valid_i;
  logic [WARP_LOG-1:0]               issue_warp_i;
  logic [SLOT_LOG-1:0]               issue_slot_i;
  logic [PC_W-1:0]                   icache_pc_o;
  logic [FETCH_W*INST_W-1:0]         icache_inst_i;
  logic [WARP_LOG-1:0]               fetch_warp_o;
  logic [FETCH_W-1:0]                pkt_valid_o;
  logic [FETCH_W*(INST_W+PC_W)-1:0]  pkt_o;
  logic [NUM_WARP-1:0]               warp_run_o;
  logic                              all_done_o;

  modport slave (
    input  stall_i, launch_valid_i, launch_warp_i, launch_pc_i,
           redir_valid_i, redir_warp_i, redir_pc_i, exit_valid_i, exit_warp_i,
           issue_valid_i, issue_warp_i, issue_slot_i, icache_inst_i,
    output icache_pc_o, fetch_warp_o, pkt_valid_o, pkt_o, warp_run_o, all_done_o
  );

  modport master (
    output stall_i, launch_valid_i, launch_warp_i, launch_pc_i,
           redir_valid_i, redir_warp_i, redir_pc_i, exit_valid_i, exit_warp_i,
           issue_valid_i, issue_warp_i, issue_slot_i, icache_inst_i,
    input  icache_pc_o, fetch_warp_o, pkt_valid_o, pkt_o, warp_run_o, all_done_o
  );
endinterface

// File: rtl/fetch_rr_arbiter.sv
// Rotating-priority arbiter: first requester after last_grant (with wrap) wins; purely combinational.
module fetch_rr_arbiter #(
  parameter int NUM_WARP = 8
) (
  input  logic [NUM_WARP-1:0]         req_i,
  input  logic [$clog2(NUM_WARP)-1:0] last_grant_i,
  output logic [$clog2(NUM_WARP)-1:0] grant_o,
  output logic                        any_o
);
  localparam int WARP_LOG = $clog2(NUM_WARP);

  int idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_WARP; i++) begin
      idx = (int'(last_grant_i) + i) % NUM_WARP;
      if (!any_o && req_i[WARP_LOG'(idx)]) begin
        any_o   = 1'b1;
        grant_o = WARP_LOG'(idx);
      end
    end
  end
endmodule

// File: rtl/warp_fetch_unit.sv
// Multi-warp fetch stage: per-warp PC/run state, round-robin grant, 0-cycle I-cache read to packets.
// Optional build macro WARP_FETCH_PERF_EN adds saturating fire / idle-cycle counters.
module warp_fetch_unit
  import simd_fetch_pkg::*;
#(
  parameter int              NUM_WARP = NUM_WARP_DEF,
  parameter int              FETCH_W  = FETCH_W_DEF,
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] END_PC   = PC_W'(32'h400)
) (
  input  logic               clk,
  input  logic               reset,
  warp_fetch_unit_if.slave   bus
`ifdef WARP_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt_o,
  output logic [31:0]        perf_idle_cnt_o
`endif
);
  localparam int WARP_LOG = $clog2(NUM_WARP);
  localparam int PKT_W    = INST_W + PC_W;

  warp_state_e                      state_q [NUM_WARP];
  warp_state_e                      state_d [NUM_WARP];
  logic [NUM_WARP-1:0][PC_W-1:0]    pc_q, pc_d;
  logic [NUM_WARP-1:0][FETCH_W-1:0] slot_q, slot_d;
  logic [WARP_LOG-1:0]              last_grant_q, last_grant_d;

  logic [NUM_WARP-1:0] run, eligible, exit_hit, redir_hit, launch_hit;
  logic [WARP_LOG-1:0] grant;
  logic                any, fire, active;
  logic [PC_W-1:0]     grant_pc, next_pc;
  logic [FETCH_W-1:0]  pkt_vld;

  // Nothing moves while stalled or in reset; sources hold their requests.
  assign active = ~reset & ~bus.stall_i;

  for (genvar w = 0; w < NUM_WARP; w++) begin : g_warp
    assign run[w]        = (state_q[w] == RUN);
    assign exit_hit[w]   = bus.exit_valid_i   && (bus.exit_warp_i   == WARP_LOG'(w));
    assign redir_hit[w]  = bus.redir_valid_i  && (bus.redir_warp_i  == WARP_LOG'(w));
    assign launch_hit[w] = bus.launch_valid_i && (bus.launch_warp_i == WARP_LOG'(w));
    assign eligible[w]   = run[w] && (slot_q[w] == '0) && !exit_hit[w] && !redir_hit[w];
  end

  fetch_rr_arbiter #(.NUM_WARP(NUM_WARP)) u_arb (
    .req_i        (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_o        (any)
  );

  assign fire     = any & active;
  assign grant_pc = pc_q[grant];
  assign next_pc  = grant_pc + PC_W'(FETCH_W);

  for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
    logic [PC_W-1:0] slot_pc;
    assign slot_pc    = grant_pc + PC_W'(k);
    assign pkt_vld[k] = fire && (slot_pc < END_PC);
    assign bus.pkt_o[k*PKT_W +: PKT_W] =
      pkt_vld[k] ? {bus.icache_inst_i[k*INST_W +: INST_W], slot_pc} : '0;
  end

  assign bus.icache_pc_o  = grant_pc;
  assign bus.fetch_warp_o = grant;
  assign bus.pkt_valid_o  = pkt_vld;
  assign bus.warp_run_o   = run;
  assign bus.all_done_o   = ~|run;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    slot_d       = slot_q;
    last_grant_d = last_grant_q;
    if (active) begin
      if (fire) last_grant_d = grant;
      for (int w = 0; w < NUM_WARP; w++) begin
        if (bus.issue_valid_i && (bus.issue_warp_i == WARP_LOG'(w)))
          slot_d[w][bus.issue_slot_i] = 1'b0;
        // Exit > redirect > launch > fetch; launch and fetch never share a warp.
        if (exit_hit[w]) begin
          state_d[w] = IDLE;
          slot_d[w]  = '0;
        end else if (redir_hit[w] && (state_q[w] != IDLE)) begin
          slot_d[w]  = '0;
          pc_d[w]    = bus.redir_pc_i;
          state_d[w] = (bus.redir_pc_i < END_PC) ? RUN : DONE;
        end else if (launch_hit[w] && (state_q[w] == IDLE)) begin
          pc_d[w]    = bus.launch_pc_i;
          state_d[w] = RUN;
        end else if (fire && (grant == WARP_LOG'(w))) begin
          slot_d[w] = slot_d[w] | pkt_vld;
          pc_d[w]   = next_pc;
          if (next_pc >= END_PC) state_d[w] = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARP; w++) state_q[w] <= IDLE;
      pc_q         <= '0;
      slot_q       <= '0;
      last_grant_q <= WARP_LOG'(NUM_WARP - 1);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      slot_q       <= slot_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WARP_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, idle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      if (fire && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (active && !fire && (|run) && (idle_cnt_q != '1)) idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_idle_cnt_o  = idle_cnt_q;
`endif
endmodule

// File: tb/tb_warp_fetch_unit.sv
// Directed bench for warp_fetch_unit: launch, RR grant, END_PC boundary, redirect/exit, stall, reset.
module tb_warp_fetch_unit;
  import simd_fetch_pkg::*;

  localparam int NW = 8;
  localparam int FW = 2;
  localparam int PW = 32;
  localparam int IW = 64;
  localparam int PK = IW + PW;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  warp_fetch_unit_if #(.NUM_WARP(NW), .FETCH_W(FW), .PC_W(PW), .INST_W(IW)) bus ();

`ifdef WARP_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_idle;
`endif

  warp_fetch_unit #(.NUM_WARP(NW), .FETCH_W(FW), .PC_W(PW), .INST_W(IW), .END_PC(32'h400)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef WARP_FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_idle_cnt_o  (perf_idle)
`endif
  );

  function automatic logic [IW-1:0] inst_of(input logic [PW-1:0] pc);
    return {32'hC0DE_F00D, pc};
  endfunction

  // I-cache model: returns data for the address the DUT presents, same cycle.
  assign bus.icache_inst_i = {inst_of(bus.icache_pc_o + 32'd1), inst_of(bus.icache_pc_o)};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then drop all one-shot requests for the new cycle.
  task automatic next();
    @(posedge clk);
    #1;
    bus.launch_valid_i = 1'b0;
    bus.redir_valid_i  = 1'b0;
    bus.exit_valid_i   = 1'b0;
    bus.issue_valid_i  = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic launch(input int w, input logic [PW-1:0] pc);
    bus.launch_valid_i = 1'b1;
    bus.launch_warp_i  = 3'(w);
    bus.launch_pc_i    = pc;
  endtask

  task automatic issue(input int w, input int s);
    bus.issue_valid_i = 1'b1;
    bus.issue_warp_i  = 3'(w);
    bus.issue_slot_i  = 1'(s);
  endtask

  task automatic redir(input int w, input logic [PW-1:0] pc);
    bus.redir_valid_i = 1'b1;
    bus.redir_warp_i  = 3'(w);
    bus.redir_pc_i    = pc;
  endtask

  task automatic chk_fetch(input string tag, input int w, input logic [PW-1:0] pc,
                           input logic [FW-1:0] vld);
    fetch_pkt_t exp_pkt;
    chk({tag, "_vld"},  128'(bus.pkt_valid_o), 128'(vld));
    chk({tag, "_warp"}, 128'(bus.fetch_warp_o), 128'(w));
    chk({tag, "_pc"},   128'(bus.icache_pc_o), 128'(pc));
    for (int k = 0; k < FW; k++) begin
      exp_pkt = vld[k] ? {inst_of(pc + PW'(k)), pc + PW'(k)} : '0;
      chk($sformatf("%s_pkt%0d", tag, k), 128'(bus.pkt_o[k*PK +: PK]), 128'(exp_pkt));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, 128'(bus.pkt_valid_o), 128'(2'b00));
  endtask

  initial begin
    reset = 1'b1;
    bus.stall_i = 1'b0;
    bus.launch_valid_i = 1'b0; bus.launch_warp_i = '0; bus.launch_pc_i = '0;
    bus.redir_valid_i  = 1'b0; bus.redir_warp_i  = '0; bus.redir_pc_i  = '0;
    bus.exit_valid_i   = 1'b0; bus.exit_warp_i   = '0;
    bus.issue_valid_i  = 1'b0; bus.issue_warp_i  = '0; bus.issue_slot_i = '0;
    next(); next();
    settle();
    chk("rst_vld", 128'(bus.pkt_valid_o), 128'(0));
    chk("rst_done", 128'(bus.all_done_o), 128'(1));
    chk("rst_run", 128'(bus.warp_run_o), 128'(0));
    chk("rst_pc", 128'(bus.icache_pc_o), 128'(0));
    reset = 1'b0;

    // Launch w0; it is fetched the following cycle, warp 0 winning first.
    launch(0, 32'h0); settle(); chk_idle("A");
    next(); settle();
    chk_fetch("B", 0, 32'h0, 2'b11);
    chk("B_run", 128'(bus.warp_run_o), 128'(8'h01));
    chk("B_done", 128'(bus.all_done_o), 128'(0));

    // w1..w3 each fetched once in RR order; w2 starts one below END_PC.
    next(); launch(1, 32'h10);  settle(); chk_idle("C");
    next(); launch(2, 32'h3FF); settle(); chk_fetch("D", 1, 32'h10, 2'b11);
    next(); launch(3, 32'h20);  settle(); chk_fetch("E", 2, 32'h3FF, 2'b01);
    next(); settle();
    chk_fetch("F", 3, 32'h20, 2'b11);
    chk("F_run", 128'(bus.warp_run_o), 128'(8'h0B));
    next(); settle(); chk_idle("G");

    // Drain w1's slots; it is refetched at pc 0x12.
    next(); issue(1, 0); settle(); chk_idle("H");
    next(); issue(1, 1); settle(); chk_idle("I");
    next(); settle(); chk_fetch("J", 1, 32'h12, 2'b11);

    // Redirect + exit of an eligible w1 in one cycle: exit wins, no fetch.
    next(); issue(1, 0); settle(); chk_idle("K1");
    next(); issue(1, 1); settle(); chk_idle("K2");
    next(); redir(1, 32'h40);
    bus.exit_valid_i = 1'b1; bus.exit_warp_i = 3'd1;
    settle(); chk_idle("K3");
    next(); settle();
    chk_idle("K4");
    chk("K4_run", 128'(bus.warp_run_o), 128'(8'h09));

    // Redirect of an eligible w3 masks it this cycle; next fetch uses the new PC.
    next(); issue(3, 0); settle(); chk_idle("L1");
    next(); issue(3, 1); settle(); chk_idle("L2");
    next(); redir(3, 32'h80); settle(); chk_idle("L3");
    next(); settle(); chk_fetch("L4", 3, 32'h80, 2'b11);

    // Two pending warps (w5, w6) held across a 3-cycle stall; launch during stall ignored.
    next(); launch(5, 32'h100); settle(); chk_idle("M1");
    next(); launch(6, 32'h300); redir(5, 32'h200); settle(); chk_idle("M2");
    for (int c = 0; c < 3; c++) begin
      next(); bus.stall_i = 1'b1; launch(7, 32'h0); settle();
      chk_idle($sformatf("STALL%0d", c));
      chk($sformatf("STALL%0d_run", c), 128'(bus.warp_run_o), 128'(8'h69));
    end
    next(); bus.stall_i = 1'b0; settle();
    chk_fetch("M6", 5, 32'h200, 2'b11);
    chk("M6_run", 128'(bus.warp_run_o), 128'(8'h69));
    next(); settle(); chk_fetch("M7", 6, 32'h300, 2'b11);

    // Reset with w5 eligible: no packet that cycle, everything cleared after.
    next(); issue(5, 0); settle(); chk_idle("M8");
    next(); issue(5, 1); settle(); chk_idle("M9");
`ifdef WARP_FETCH_PERF_EN
    chk("perf_fetch", 128'(perf_fetch), 128'(8));
`endif
    next(); reset = 1'b1; settle(); chk_idle("M10");
    next(); reset = 1'b0; settle();
    chk_idle("M11");
    chk("M11_run", 128'(bus.warp_run_o), 128'(0));
    chk("M11_done", 128'(bus.all_done_o), 128'(1));
`ifdef WARP_FETCH_PERF_EN
    chk("perf_rst", 128'(perf_fetch), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
